lsu_mem_stage: RTL and testbench

Parametrised load/store unit for the memory stage of the five-stage MIPS pipeline, successor to the single-cycle data-memory path. It owns a word-organised data RAM of configurable depth and supports byte/half/word stores with byte enables and sign/zero-extended loads. Loads complete after a configurable latency and hold the pipeline through a stall handshake. Misaligned accesses are flagged as AdEL/AdES for the exception unit instead of being silently truncated.

---
 rtl/lsu_mem_stage.sv | 161 ++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit with a word-organised data RAM,
// byte/half/word stores, sign/zero-extended multi-cycle loads and AdEL/AdES flags.
module lsu_mem_stage #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        adel,
    output logic        ades
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {
        W_WORD     = 2'b00,
        W_HALF     = 2'b01,
        W_BYTE     = 2'b10,
        W_WORD_ALT = 2'b11
    } width_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    width_t            width;
    logic [ADDR_W-1:0] idx;
    logic              misaligned;
    logic              load_accept;
    logic              store_en;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       wmask;
    logic [31:0]       mem [DEPTH];

    logic [31:0]       lat_word;
    logic [1:0]        lat_off;
    width_t            lat_width;
    logic              lat_sign;
    logic [31:0]       byte_sh;
    logic [15:0]       half_v;
    logic [31:0]       ext;
    logic              unused_addr_bits;

    assign width            = width_t'(req_width);
    assign idx              = req_addr[ADDR_W+1:2];
    // High address bits are deliberately dropped so accesses wrap around the RAM.
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wlane      = req_wdata;
        case (width)
            W_HALF: begin
                misaligned = req_addr[0];
                be         = req_addr[1] ? 4'b1100 : 4'b0011;
                wlane      = {2{req_wdata[15:0]}};
            end
            W_BYTE: begin
                be    = 4'b0001 << req_addr[1:0];
                wlane = {4{req_wdata[7:0]}};
            end
            default: misaligned = |req_addr[1:0];
        endcase
    end

    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign adel  = (state_q == IDLE) && req_valid && misaligned && !req_we;
    assign ades  = (state_q == IDLE) && req_valid && misaligned && req_we;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        load_accept = 1'b0;
        store_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !misaligned) begin
                    if (req_we) begin
                        store_en = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        load_accept = 1'b1;
                        if (LATENCY == 1) begin
                            state_d = DONE;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == 3'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the whole array is cleared in one reset cycle, so it cannot map to a block RAM.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        always_ff @(posedge clk) begin
            if (reset) begin
                mem[w] <= '0;
            end else if (store_en && idx == ADDR_W'(w)) begin
                mem[w] <= (mem[w] & ~wmask) | (wlane & wmask);
            end
        end
    end

    // Load operands are captured at accept; rd_data is gated by rd_valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            lat_word  <= mem[idx];
            lat_off   <= req_addr[1:0];
            lat_width <= width;
            lat_sign  <= req_sign;
        end
    end

    assign byte_sh = lat_word >> {lat_off, 3'b000};
    assign half_v  = lat_off[1] ? lat_word[31:16] : lat_word[15:0];

    always_comb begin
        ext = lat_word;
        case (lat_width)
            W_HALF:  ext = {{16{lat_sign & half_v[15]}}, half_v};
            W_BYTE:  ext = {{24{lat_sign & byte_sh[7]}}, byte_sh[7:0]};
            default: ext = lat_word;
        endcase
    end

    assign rd_valid = (state_q == DONE);
    assign rd_data  = rd_valid ? ext : 32'h0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: u_a uses defaults (ADDR_W=12, LATENCY=1),
// u_b uses ADDR_W=4, LATENCY=4; load results are checked through a scoreboard queue.
module tb_lsu_mem_stage;
    localparam logic [1:0] WD = 2'b00;
    localparam logic [1:0] HF = 2'b01;
    localparam logic [1:0] BY = 2'b10;
    localparam logic [1:0] WX = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  reset;
    logic [1:0]  req_valid, req_we, req_sign;
    logic [1:0]  req_width [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  stall, rd_valid, adel, ades;
    logic [31:0] rd_data   [2];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    lsu_mem_stage u_a (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_width(req_width[0]), .req_sign(req_sign[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .stall(stall[0]), .rd_valid(rd_valid[0]),
        .rd_data(rd_data[0]), .adel(adel[0]), .ades(ades[0])
    );

    lsu_mem_stage #(.ADDR_W(4), .LATENCY(4)) u_b (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_width(req_width[1]), .req_sign(req_sign[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .stall(stall[1]), .rd_valid(rd_valid[1]),
        .rd_data(rd_data[1]), .adel(adel[1]), .ades(ades[1])
    );

    task automatic drive(input int b, input bit v, input bit we, input logic [1:0] w,
                         input bit s, input logic [31:0] a, input logic [31:0] d);
        req_valid[b] = v;
        req_we[b]    = we;
        req_width[b] = w;
        req_sign[b]  = s;
        req_addr[b]  = a;
        req_wdata[b] = d;
    endtask

    task automatic idle(input int b);
        @(negedge clk);
        req_valid[b] = 1'b0;
    endtask

    task automatic apply_reset(input int b);
        @(negedge clk);
        reset[b]     = 1'b1;
        req_valid[b] = 1'b0;
        @(negedge clk);
        reset[b] = 1'b0;
    endtask

    task automatic do_store(input int b, input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        @(negedge clk);
        drive(b, 1'b1, 1'b1, w, 1'b0, a, d);
        #1;
        vectors++;
        if ({stall[b], adel[b], ades[b]} !== 3'b000) begin
            miscompares++;
            $display("FAIL store@%h stall/adel/ades=%b expected 000", a, {stall[b], adel[b], ades[b]});
        end
    endtask

    task automatic do_misaligned(input int b, input string name, input logic [31:0] a,
                                 input logic [1:0] w, input bit we);
        @(negedge clk);
        drive(b, 1'b1, we, w, 1'b0, a, 32'h0000_1111);
        #1;
        vectors++;
        if ({adel[b], ades[b], stall[b]} !== {~we, we, 1'b0}) begin
            miscompares++;
            $display("FAIL %s adel/ades/stall=%b expected %b", name, {adel[b], ades[b], stall[b]},
                     {~we, we, 1'b0});
        end
    endtask

    // Issues one load, counts stall cycles and compares the delivered word with the scoreboard.
    task automatic do_load(input int b, input string name, input logic [31:0] a, input logic [1:0] w,
                           input bit s, input logic [31:0] expv, input int lat, output int done_cyc);
        int          stalls = 0;
        bit          got    = 1'b0;
        logic [31:0] e;
        done_cyc = -1;
        exp_q.push_back(expv);
        @(negedge clk);
        drive(b, 1'b1, 1'b0, w, s, a, 32'h0);
        #1;
        vectors++;
        if ({adel[b], ades[b]} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s aligned flags adel/ades=%b expected 00", name, {adel[b], ades[b]});
        end
        for (int c = 0; c < lat + 4; c++) begin
            if (rd_valid[b] === 1'b1) begin
                got          = 1'b1;
                done_cyc     = cyc;
                req_valid[b] = 1'b0;
                e            = exp_q.pop_front();
                vectors++;
                if (rd_data[b] !== e) begin
                    miscompares++;
                    $display("FAIL %s rd_data=%h expected %h", name, rd_data[b], e);
                end
                vectors++;
                if (stalls != lat) begin
                    miscompares++;
                    $display("FAIL %s stall_cycles=%0d expected %0d", name, stalls, lat);
                end
                vectors++;
                if (stall[b] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s stall_with_rd_valid=%b expected 0", name, stall[b]);
                end
                break;
            end
            if (stall[b] === 1'b1) stalls++;
            @(negedge clk);
            #1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            req_valid[b] = 1'b0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            $display("FAIL %s timeout rd_valid=0 after %0d cycles expected 1", name, lat + 4);
        end
    endtask

    task automatic test_reset(input int b);
        apply_reset(b);
        #1;
        vectors++;
        if ({stall[b], rd_valid[b], adel[b], ades[b]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset%0d stall/rd_valid/adel/ades=%b expected 0000", b,
                     {stall[b], rd_valid[b], adel[b], ades[b]});
        end
        vectors++;
        if (rd_data[b] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset%0d rd_data=%h expected 00000000", b, rd_data[b]);
        end
    endtask

    task automatic test_first_load();
        int d;
        do_load(0, "lw_0x10_after_reset", 32'h10, WD, 1'b0, 32'h0, 1, d);
    endtask

    task automatic test_byte_half();
        int d;
        do_store(0, 32'h20, WD, 32'h8899_AABB);
        do_load(0, "lb_0x21", 32'h21, BY, 1'b1, 32'hFFFF_FFAA, 1, d);
        do_load(0, "lbu_0x23", 32'h23, BY, 1'b0, 32'h0000_0088, 1, d);
        do_load(0, "lh_0x22", 32'h22, HF, 1'b1, 32'hFFFF_8899, 1, d);
        do_load(0, "lhu_0x20", 32'h20, HF, 1'b0, 32'h0000_AABB, 1, d);
        do_load(0, "lb_0x20_pos", 32'h20, BY, 1'b1, 32'hFFFF_FFBB, 1, d);
        do_load(0, "lw_sign_ignored", 32'h20, WD, 1'b1, 32'h8899_AABB, 1, d);
    endtask

    task automatic test_partial_store();
        int d;
        do_store(0, 32'h30, WD, 32'hFFFF_FFFF);
        do_store(0, 32'h32, HF, 32'hABCD_1234);
        do_load(0, "lw_after_sh", 32'h30, WD, 1'b0, 32'h1234_FFFF, 1, d);
        do_store(0, 32'h31, BY, 32'h7777_775A);
        do_load(0, "lw_after_sb", 32'h30, WD, 1'b0, 32'h1234_5AFF, 1, d);
        do_store(0, 32'h44, WX, 32'hA5A5_5A5A);
        do_load(0, "lw_width11", 32'h44, WX, 1'b1, 32'hA5A5_5A5A, 1, d);
    endtask

    task automatic test_misaligned();
        int d;
        do_store(0, 32'h04, WD, 32'hCAFE_F00D);
        do_misaligned(0, "lw_0x02", 32'h02, WD, 1'b0);
        idle(0);
        #1;
        vectors++;
        if ({rd_valid[0], stall[0]} !== 2'b00) begin
            miscompares++;
            $display("FAIL lw_0x02_no_access rd_valid/stall=%b expected 00", {rd_valid[0], stall[0]});
        end
        do_misaligned(0, "sh_0x05", 32'h05, HF, 1'b1);
        do_misaligned(0, "lh_0x03", 32'h03, HF, 1'b0);
        idle(0);
        do_load(0, "lw_0x04_unchanged", 32'h04, WD, 1'b0, 32'hCAFE_F00D, 1, d);
    endtask

    task automatic test_reset_priority();
        int d;
        do_store(0, 32'h50, WD, 32'h1111_2222);
        @(negedge clk);
        reset[0] = 1'b1;
        drive(0, 1'b1, 1'b1, WD, 1'b0, 32'h54, 32'h9999_9999);
        @(negedge clk);
        reset[0]     = 1'b0;
        req_valid[0] = 1'b0;
        do_load(0, "lw_0x54_store_lost", 32'h54, WD, 1'b0, 32'h0, 1, d);
        do_load(0, "lw_0x50_cleared", 32'h50, WD, 1'b0, 32'h0, 1, d);
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        do_store(0, 32'h60, WD, 32'h0000_00A1);
        do_store(0, 32'h64, WD, 32'h0000_00B2);
        do_load(0, "b2b_first", 32'h60, WD, 1'b0, 32'h0000_00A1, 1, d1);
        do_load(0, "b2b_second", 32'h64, WD, 1'b0, 32'h0000_00B2, 1, d2);
        vectors++;
        if (d2 - d1 != 2) begin
            miscompares++;
            $display("FAIL b2b_spacing cycles=%0d expected 2", d2 - d1);
        end
    endtask

    task automatic test_latency();
        int d;
        do_store(1, 32'h08, WD, 32'hDEAD_BEEF);
        do_load(1, "lw_lat4", 32'h08, WD, 1'b0, 32'hDEAD_BEEF, 4, d);
        do_load(1, "lh_lat4", 32'h0A, HF, 1'b1, 32'hFFFF_DEAD, 4, d);
    endtask

    task automatic test_reset_abort();
        int d;
        int pulses = 0;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, WD, 1'b0, 32'h08, 32'h0);
        #1;
        vectors++;
        if (stall[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_accept stall=%b expected 1", stall[1]);
        end
        @(negedge clk);
        reset[1] = 1'b1;
        drive(1, 1'b1, 1'b0, WD, 1'b0, 32'h02, 32'h0);
        #1;
        vectors++;
        if ({stall[1], adel[1]} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_busy stall/adel=%b expected 10", {stall[1], adel[1]});
        end
        @(negedge clk);
        reset[1]     = 1'b0;
        req_valid[1] = 1'b0;
        #1;
        vectors++;
        if ({stall[1], rd_valid[1]} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_after_reset stall/rd_valid=%b expected 00", {stall[1], rd_valid[1]});
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (rd_valid[1] === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL abort_no_response rd_valid_pulses=%0d expected 0", pulses);
        end
        do_load(1, "lw_after_abort_cleared", 32'h08, WD, 1'b0, 32'h0, 4, d);
    endtask

    task automatic test_alias();
        int d;
        do_store(1, 32'h40, WD, 32'h1357_9BDF);
        do_load(1, "alias_lw_0x00", 32'h00, WD, 1'b0, 32'h1357_9BDF, 4, d);
        do_load(1, "alias_lw_high", 32'hFFFF_FFC0, WD, 1'b0, 32'h1357_9BDF, 4, d);
    endtask

    initial begin
        reset     = 2'b11;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_sign  = 2'b00;
        for (int b = 0; b < 2; b++) begin
            req_width[b] = WD;
            req_addr[b]  = 32'h0;
            req_wdata[b] = 32'h0;
        end
        test_reset(0);
        test_reset(1);
        test_first_load();
        test_byte_half();
        test_partial_store();
        test_misaligned();
        test_reset_priority();
        test_back_to_back();
        test_latency();
        test_reset_abort();
        test_alias();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
